// File: rtl/iob_spi_fl_slave_pkg.sv
// iob_spi_fl_slave_pkg: opcodes, states and status bits for the SPI flash responder
package iob_spi_fl_slave_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_RD, ST_WR, ST_STAT, ST_ID, ST_IGNORE
  } state_t;
  function automatic state_t cmd_next(input logic [7:0] c);
    return (c == CMD_READ || c == CMD_PP) ? ST_ADDR :
           c == CMD_RDSR ? ST_STAT :
           c == CMD_RDID ? ST_ID : ST_IGNORE;
  endfunction
endpackage

// File: rtl/spi_slave_sync_edge.sv
// spi_slave_sync_edge: two-flop synchroniser with registered rise/fall pulses aligned to q
module spi_slave_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s <= {s[1:0], d};
      rise <= s[1] & ~s[2];
      fall <= ~s[1] & s[2];
    end
  assign q = s[2];
endmodule

// File: rtl/iob_spi_slave_fl.sv
// iob_spi_slave_fl: SPI mode-0 serial-NOR flash responder over a byte-wide memory port
module iob_spi_slave_fl import iob_spi_fl_slave_pkg::*; #(
  parameter int MEM_ADDR_W = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018,
  parameter int PAGE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  cmd_strobe,
  output logic [7:0]            cmd_code
);
  localparam logic [MEM_ADDR_W-1:0] PMASK = MEM_ADDR_W'((1 << PAGE_W) - 1);
  logic sclk_q, sclk_rise, sclk_fall, ss_q, ss_rise, ss_fall, mosi_q, mosi_rise, mosi_fall;
  logic unused;
  state_t state, state_nxt;
  logic [2:0] bitcnt;
  logic [1:0] acnt, id_cnt;
  logic [7:0] sh_in, sh_out, byte_val, stat, id_byte;
  logic [MEM_ADDR_W-1:0] addr;
  logic wel, wrote, skip, en_q, we_q, rd_load;
  logic rise, fall, byte_done, out_st, boundary;
  spi_slave_sync_edge u_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_slave_sync_edge u_ss   (.clk(clk), .rst(rst), .d(ss),   .q(ss_q),   .rise(ss_rise),   .fall(ss_fall));
  spi_slave_sync_edge u_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
  assign unused = ^{sclk_q, mosi_rise, mosi_fall};
  assign rise = sclk_rise & ~ss_q & (state != ST_IDLE);
  assign fall = sclk_fall & ~ss_q;
  assign byte_done = rise & (bitcnt == 3'd7);
  assign byte_val = {sh_in[6:0], mosi_q};
  assign out_st = state inside {ST_RD, ST_STAT, ST_ID};
  // the fall right after the byte that entered a data-out state belongs to that byte, not the next
  assign boundary = fall & out_st & ~skip & (bitcnt == 3'd0);
  assign miso_oe = out_st;
  assign miso = out_st & sh_out[7];
  assign mem_en = en_q & ~ss_q;
  assign mem_we = we_q & ~ss_q;
  assign mem_addr = addr;
  always_comb begin
    stat = '0;
    stat[SR_WEL] = wel;
    stat[SR_WIP] = 1'b0;
    id_byte = id_cnt == 2'd1 ? JEDEC_ID[15:8] : id_cnt == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
  end
  always_comb begin
    state_nxt = state;
    if (ss_q) state_nxt = ST_IDLE;
    else if (state == ST_IDLE) state_nxt = ss_fall ? ST_CMD : ST_IDLE;
    else if (byte_done && state == ST_CMD) state_nxt = cmd_next(byte_val);
    else if (byte_done && state == ST_ADDR && acnt == 2'd2) state_nxt = cmd_code == CMD_READ ? ST_RD : ST_WR;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ST_IDLE;
      bitcnt <= '0;
      acnt <= '0;
      id_cnt <= '0;
      sh_in <= '0;
      sh_out <= '0;
      addr <= '0;
      wel <= 1'b0;
      wrote <= 1'b0;
      skip <= 1'b0;
      en_q <= 1'b0;
      we_q <= 1'b0;
      rd_load <= 1'b0;
      mem_wdata <= '0;
      cmd_strobe <= 1'b0;
      cmd_code <= '0;
    end else begin
      state <= state_nxt;
      en_q <= 1'b0;
      we_q <= 1'b0;
      cmd_strobe <= 1'b0;
      rd_load <= mem_en & ~mem_we;
      if (mem_en & mem_we) begin
        addr <= (addr & ~PMASK) | ((addr + MEM_ADDR_W'(1)) & PMASK);
        wrote <= 1'b1;
      end
      if (ss_rise & wrote) wel <= 1'b0;
      if (ss_q) begin
        bitcnt <= '0;
        acnt <= '0;
        id_cnt <= '0;
        sh_in <= '0;
        sh_out <= '0;
        skip <= 1'b0;
        wrote <= 1'b0;
      end else begin
        if (rise) begin
          sh_in <= byte_val;
          bitcnt <= bitcnt + 3'd1;
        end
        if (fall & out_st) skip <= 1'b0;
        if (byte_done && state == ST_CMD) begin
          cmd_strobe <= 1'b1;
          cmd_code <= byte_val;
          if (byte_val == CMD_WREN) wel <= 1'b1;
          if (byte_val == CMD_WRDI) wel <= 1'b0;
          sh_out <= byte_val == CMD_RDID ? JEDEC_ID[23:16] : stat;
          id_cnt <= 2'd1;
          skip <= 1'b1;
        end
        if (byte_done && state == ST_ADDR) begin
          addr <= MEM_ADDR_W'({addr, byte_val});
          acnt <= acnt + 2'd1;
          if (acnt == 2'd2 && cmd_code == CMD_READ) begin
            en_q <= 1'b1;
            skip <= 1'b1;
          end
        end
        if (byte_done && state == ST_WR && wel) begin
          en_q <= 1'b1;
          we_q <= 1'b1;
          mem_wdata <= byte_val;
        end
        if (boundary) begin
          sh_out <= state == ST_STAT ? stat : state == ST_ID ? id_byte : sh_out;
          if (state == ST_ID && id_cnt != 2'd3) id_cnt <= id_cnt + 2'd1;
          if (state == ST_RD) begin
            addr <= addr + MEM_ADDR_W'(1);
            en_q <= 1'b1;
          end
        end else if (fall & out_st & ~skip) sh_out <= {sh_out[6:0], 1'b0};
        if (rd_load && state == ST_RD) sh_out <= mem_rdata;
      end
    end
endmodule

// File: tb/tb_iob_spi_slave_fl.sv
// tb_iob_spi_slave_fl: directed bench driving SPI frames into the flash responder
module tb_iob_spi_slave_fl;
  logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, mem_en, mem_we, cmd_strobe;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata, cmd_code, rx;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [0:65535];
  logic [15:0] rq[$];
  logic [23:0] wq[$];
  int n_run = 0, n_fail = 0, n_stb = 0, base = 0;

  always #5 clk = ~clk;

  iob_spi_slave_fl dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cmd_strobe(cmd_strobe), .cmd_code(cmd_code)
  );

  always @(posedge clk) begin
    if (cmd_strobe) n_stb++;
    if (mem_en && !mem_we) begin
      mem_rdata <= mem[mem_addr];
      rq.push_back(mem_addr);
    end
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wq.push_back({mem_addr, mem_wdata});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0 master: drive mosi while sclk low, sample miso just before the rise
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      #80;
      r = {r[6:0], miso};
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic ss_lo;
    ss = 1'b0;
    #80;
  endtask

  task automatic ss_hi;
    #80;
    ss = 1'b1;
    #200;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h3C;
    #20;
    chk("rst_ctl", {miso, miso_oe, mem_en, mem_we, cmd_strobe, cmd_code}, 0);
    chk("rst_mem", {mem_addr, mem_wdata}, 0);
    rst = 1'b1;
    #100;
    // read two bytes from 0x0010
    ss_lo;
    xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h00, 8, rx); xfer(8'h10, 8, rx);
    xfer(8'h00, 8, rx); chk("rd_b0", rx, 8'hA5);
    xfer(8'h00, 8, rx); chk("rd_b1", rx, 8'h3C);
    chk("rd_oe", miso_oe, 1'b1);
    ss_hi;
    chk("rd_cnt", (rq.size() >= 2 && rq.size() <= 3), 1'b1);
    chk("rd_a0", rq[0], 16'h0010);
    chk("rd_a1", rq[1], 16'h0011);
    chk("rd_code", cmd_code, 8'h03);
    chk("rd_oe_off", {miso_oe, miso}, 2'b00);
    // write enable, then page program across the page end
    ss_lo; xfer(8'h06, 8, rx); ss_hi;
    ss_lo;
    xfer(8'h02, 8, rx); xfer(8'h00, 8, rx); xfer(8'h01, 8, rx); xfer(8'hFE, 8, rx);
    xfer(8'h11, 8, rx); xfer(8'h22, 8, rx); xfer(8'h33, 8, rx);
    ss_hi;
    chk("wr_cnt", wq.size(), 3);
    chk("wr0", wq[0], {16'h01FE, 8'h11});
    chk("wr1", wq[1], {16'h01FF, 8'h22});
    chk("wr2", wq[2], {16'h0100, 8'h33});
    ss_lo; xfer(8'h05, 8, rx); xfer(8'h00, 8, rx); ss_hi;
    chk("sr_after_pp", rx, 8'h00);
    // program without write enable
    ss_lo;
    xfer(8'h02, 8, rx); xfer(8'h00, 8, rx); xfer(8'h00, 8, rx); xfer(8'h00, 8, rx);
    xfer(8'h55, 8, rx);
    ss_hi;
    chk("wr_noen", wq.size(), 3);
    ss_lo; xfer(8'h05, 8, rx); xfer(8'h00, 8, rx); ss_hi;
    chk("sr_noen", rx, 8'h00);
    // sclk activity with ss high must not start a command
    mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #80 sclk = 1'b1;
      #80 sclk = 1'b0;
    end
    #200;
    base = n_stb;
    ss_lo;
    xfer(8'h9F, 8, rx);
    xfer(8'h00, 8, rx); chk("id0", rx, 8'hEF);
    xfer(8'h00, 8, rx); chk("id1", rx, 8'h40);
    xfer(8'h00, 8, rx); chk("id2", rx, 8'h18);
    xfer(8'h00, 8, rx); chk("id3", rx, 8'h00);
    ss_hi;
    chk("id_stb", n_stb - base, 1);
    chk("id_code", cmd_code, 8'h9F);
    // address aborted after 12 bits
    base = rq.size();
    ss_lo;
    xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h00, 4, rx);
    ss_hi;
    chk("abort_rd", rq.size(), base);
    ss_lo; xfer(8'h06, 8, rx); ss_hi;
    ss_lo; xfer(8'h05, 8, rx); xfer(8'h00, 8, rx); ss_hi;
    chk("sr_wel", rx, 8'h02);
    // reset in the middle of a read
    ss_lo;
    xfer(8'h03, 8, rx); xfer(8'h00, 8, rx); xfer(8'h00, 8, rx); xfer(8'h10, 8, rx);
    xfer(8'h00, 3, rx);
    #40;
    chk("mid_oe", miso_oe, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {miso, miso_oe, mem_en, mem_we, cmd_strobe, cmd_code}, 0);
    chk("mid_rst_mem", {mem_addr, mem_wdata}, 0);
    #9;
    ss = 1'b1;
    #100;
    rst = 1'b1;
    #200;
    ss_lo; xfer(8'h05, 8, rx); xfer(8'h00, 8, rx); ss_hi;
    chk("sr_post_rst", rx, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/iob_spi_slave_fl.md
Name: iob_spi_slave_fl

Overview:
- Single-bit SPI flash responder (SPI mode 0) that answers the command frames issued by the team's flash SPI master.
- Lets system benches and FPGA loopback builds exercise the master with no physical flash part.
- Decodes a serial-NOR command subset, services reads and page programs through a synchronous byte-wide memory port, and keeps a status register.
- SCLK, SS and MOSI are oversampled in the clk domain. Requirement: SCLK half-period ≥ 4 clk cycles.

Parameters:
- MEM_ADDR_W, 16, memory-port address width; the 24-bit SPI address is truncated to its low MEM_ADDR_W bits.
- JEDEC_ID, 24'hEF4018, returned MSB-first by READ ID.
- PAGE_W, 8, log2 of the page size for PAGE PROGRAM wrap.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock from master (asynchronous)
- ss  in  1  chip select, active-low (asynchronous)
- mosi  in  1  serial data from master
- miso  out  1  serial data to master
- miso_oe  out  1  high while responder drives miso
- mem_en  out  1  memory access strobe, one cycle
- mem_we  out  1  write qualifier for mem_en
- mem_addr  out  MEM_ADDR_W  memory byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid 1 cycle after mem_en & ~mem_we
- cmd_strobe  out  1  one-cycle pulse when the command byte completes
- cmd_code  out  8  last decoded command byte

Behaviour:
- Reset (rst=0): all outputs 0; state IDLE; WEL=0; shift registers cleared.
- Synchronisers:
  - 2-FF synchronisers on sclk, ss and mosi; edge detect on synced sclk.
  - Rise/fall events are seen 3 clk after the pin edge.
- Frame handling:
  - Synced ss high forces IDLE from any state, in the same cycle it is seen.
  - A partial byte is discarded and miso_oe drops.
- Bit timing:
  - mosi is sampled on SCLK rise, MSB first.
  - miso changes on SCLK fall.
  - The first output bit is placed on miso when the state enters a data-out state, before the next rise.
- bitcnt (3b): counts sampled bits and wraps 7→0. A byte is complete when bitcnt wraps.
- States and transitions:
  - IDLE → CMD: on synced ss falling.
  - CMD: at byte 0 completion, pulse cmd_strobe and latch cmd_code, then branch:
    - 03h → ADDR
    - 02h → ADDR
    - 05h → STAT
    - 06h: set WEL → IGNORE
    - 04h: clear WEL → IGNORE
    - 9Fh → ID
    - other → IGNORE
  - ADDR: collect 24 bits; the address register holds the low MEM_ADDR_W bits.
    - On completion, 03h → RD with mem_en issued at once. 02h → WR.
  - RD:
    - mem_rdata is loaded into the out-shift register 1 cycle after mem_en.
    - After each 8th fall, address+1 (wraps at 2^MEM_ADDR_W) and the next mem_en is issued.
    - Prefetch must complete within one SCLK half-period.
  - WR:
    - For each complete byte with WEL=1: mem_en=mem_we=1 for one cycle, mem_wdata=byte.
    - The address increments only in the low PAGE_W bits, wrapping within the page.
    - With WEL=0, bytes are dropped silently.
    - When ss rises after ≥1 written byte, clear WEL.
  - STAT: shift out {6'b0, WEL, 1'b0} repeatedly while ss is low. WIP is always 0.
  - ID: shift out JEDEC_ID bytes 2,1,0, then 00h until ss rises.
  - IGNORE: miso_oe=0; wait for ss high.
- miso_oe: 1 only in RD, STAT and ID. miso=0 whenever miso_oe=0.
- Boundary cases:
  - An ss rise during ADDR issues no memory access.
  - An ss rise during a WR byte writes nothing for that byte.
  - SCLK edges while ss is high are ignored.
- mem_en never asserts in the cycle ss rising is seen.
- Latency: cmd_strobe is asserted 4 clk after the 8th SCLK rising pin edge.

Decomposition:
- Package iob_spi_fl_slave_pkg holds:
  - command opcode constants (CMD_READ=03h, CMD_PP=02h, CMD_RDSR=05h, CMD_WREN=06h, CMD_WRDI=04h, CMD_RDID=9Fh);
  - the state enum;
  - status bit indices.
- One sub-module, spi_slave_sync_edge: 2-FF sync plus rise/fall pulse generator, instantiated for sclk, ss and mosi.

Test Plan:
- Memory preloaded 0x0010=A5, 0x0011=3C. Frame 03 00 00 10 with 16 read clocks → miso returns A5 then 3C; exactly 2 mem_en reads issued (plus 1 prefetch of 0x0012 allowed); miso_oe=0 after ss rises.
- Frame 06, then frame 02 00 01 FE with data 11 22 33 → writes 0x01FE=11, 0x01FF=22, 0x0100=33 (page wrap); next 05 frame returns 00h, showing WEL was cleared.
- Frame 02 00 00 00 with data 55 without a prior 06 → no mem_en with mem_we=1; 05 frame returns 00h.
- Frame 9F with 32 clocks → miso returns EF 40 18 00; cmd_strobe pulses once; cmd_code=9Fh.
- Frame 03 00 00 with ss raised after 12 address bits → no mem_en. Then frame 06, 05 → 02h returned; the state machine recovered cleanly.
- Assert rst=0 mid-RD → all outputs 0 immediately. After release, frame 05 returns 00h.
